// File: rtl/store_retire_buffer.sv
// store_retire_buffer
// Buffers committed stores from the store queue's retire lanes and drains them,
// one at a time, into the dcache write port. Each acknowledged write produces a
// one-cycle completion carrying the store-queue position so that entry can be freed.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ret_valid/addr/data/size/pos per-lane retire inputs (N_WAY lanes)
//   squash_cmp                   flush pulse: suppress completions of buffered entries
//   buf_free                     free entries (DEPTH - count)
//   dc_req_valid/addr/data/size  dcache write request (head entry)
//   dc_req_ready                 dcache accepts the request
//   dc_ack                       dcache committed the outstanding write
//   cmp_valid/cmp_pos            completion pulse to the store queue
//   overflow_err                 sticky: a valid retire lane was dropped
module store_retire_buffer #(
  parameter int unsigned N_WAY = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned POS_W = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WAY-1:0]            ret_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]  ret_addr,
  input  logic [N_WAY-1:0][XLEN-1:0]  ret_data,
  input  logic [N_WAY-1:0][1:0]       ret_size,
  input  logic [N_WAY-1:0][POS_W-1:0] ret_pos,
  input  logic                        squash_cmp,
  output logic [$clog2(DEPTH):0]      buf_free,
  output logic                        dc_req_valid,
  output logic [XLEN-1:0]             dc_req_addr,
  output logic [XLEN-1:0]             dc_req_data,
  output logic [1:0]                  dc_req_size,
  input  logic                        dc_req_ready,
  input  logic                        dc_ack,
  output logic                        cmp_valid,
  output logic [POS_W-1:0]            cmp_pos,
  output logic                        overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [1:0]       size;
    logic [POS_W-1:0] pos;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   supp_q;
  logic [PTR_W-1:0]   head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   space_c, n_enq_c, remain_c;
  state_t             state_q, state_d;
  logic               pop_c, ovf_c, found_c;
  logic [N_WAY-1:0]   wr_en_c;
  logic [PTR_W-1:0]   wr_slot_c [N_WAY];
  entry_t             lane_c [N_WAY];
  entry_t             head_src_c;

  // Enqueue compaction, count/pointer update, next head fields and next state.
  always_comb begin
    state_d    = state_q;
    pop_c      = (state_q == S_WAIT) && dc_ack;
    // A pop this cycle frees a slot that the same cycle's enqueue may use.
    space_c    = CNT_W'(DEPTH) - count_q + CNT_W'(pop_c);
    n_enq_c    = '0;
    ovf_c      = 1'b0;
    wr_en_c    = '0;
    found_c    = 1'b0;
    for (int unsigned i = 0; i < N_WAY; i++) begin
      lane_c[i]    = '{addr: ret_addr[i], data: ret_data[i], size: ret_size[i], pos: ret_pos[i]};
      wr_slot_c[i] = tail_q + PTR_W'(n_enq_c);
      if (ret_valid[i]) begin
        if (n_enq_c < space_c) begin
          wr_en_c[i] = 1'b1;
          n_enq_c    = n_enq_c + CNT_W'(1);
        end else begin
          ovf_c = 1'b1;
        end
      end
    end
    count_d  = count_q + n_enq_c - CNT_W'(pop_c);
    head_d   = head_q + PTR_W'(pop_c);
    tail_d   = tail_q + PTR_W'(n_enq_c);
    remain_c = count_q - CNT_W'(pop_c);

    // The next head is either already stored or is being written right now.
    head_src_c = mem_q[head_d];
    if (remain_c == '0) begin
      for (int unsigned i = 0; i < N_WAY; i++) begin
        if (wr_en_c[i] && !found_c) begin
          head_src_c = lane_c[i];
          found_c    = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE:  if (count_d != '0) state_d = S_ISSUE;
      S_ISSUE: if (dc_req_ready) state_d = S_WAIT;
      S_WAIT:  if (dc_ack) state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      buf_free     <= CNT_W'(DEPTH);
      overflow_err <= 1'b0;
      dc_req_valid <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_data  <= '0;
      dc_req_size  <= '0;
      cmp_valid    <= 1'b0;
      cmp_pos      <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      buf_free     <= CNT_W'(DEPTH) - count_d;
      overflow_err <= overflow_err | ovf_c;
      dc_req_valid <= (state_d == S_ISSUE);
      if (state_d == S_ISSUE) begin
        dc_req_addr <= head_src_c.addr;
        dc_req_data <= head_src_c.data;
        dc_req_size <= head_src_c.size;
      end else begin
        dc_req_addr <= '0;
        dc_req_data <= '0;
        dc_req_size <= '0;
      end
      // A squash coinciding with the ack still counts the head as already buffered.
      cmp_valid <= pop_c && !(supp_q[head_q] || squash_cmp);
      cmp_pos   <= pop_c ? mem_q[head_q].pos : '0;
    end
  end

  // Entry storage; squash marks every slot, fresh writes clear their own mark.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (squash_cmp) supp_q <= '1;
      for (int unsigned i = 0; i < N_WAY; i++) begin
        if (wr_en_c[i]) begin
          mem_q[wr_slot_c[i]]  <= lane_c[i];
          supp_q[wr_slot_c[i]] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_retire_buffer.sv
module tb_store_retire_buffer;

  logic             clock, reset;
  logic [1:0]       ret_valid;
  logic [1:0][31:0] ret_addr, ret_data;
  logic [1:0][1:0]  ret_size;
  logic [1:0][3:0]  ret_pos;
  logic             squash_cmp;
  logic [3:0]       buf_free;
  logic             dc_req_valid;
  logic [31:0]      dc_req_addr, dc_req_data;
  logic [1:0]       dc_req_size;
  logic             dc_req_ready;
  logic             dc_ack;
  logic             cmp_valid;
  logic [3:0]       cmp_pos;
  logic             overflow_err;

  logic ack_auto, ack_man, ack_en;
  assign dc_ack = ack_auto | ack_man;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } wr_t;

  wr_t        exp_wr[$];
  logic [3:0] exp_cmp[$];
  int n_pass = 0;
  int n_chk  = 0;
  int cmp_seen = 0;

  store_retire_buffer dut (
    .clock(clock), .reset(reset),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data),
    .ret_size(ret_size), .ret_pos(ret_pos), .squash_cmp(squash_cmp),
    .buf_free(buf_free),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_size(dc_req_size),
    .dc_req_ready(dc_req_ready), .dc_ack(dc_ack),
    .cmp_valid(cmp_valid), .cmp_pos(cmp_pos), .overflow_err(overflow_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got 0x%0h required none", name, act);
  endtask

  // Put a store on a lane for the coming edge and record what it must produce.
  task automatic lane(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic [3:0] p,
                      input bit want_wr, input bit want_cmp);
    wr_t w;
    ret_valid[i] = 1'b1;
    ret_addr[i]  = a;
    ret_data[i]  = d;
    ret_size[i]  = s;
    ret_pos[i]   = p;
    w.a = a; w.d = d; w.s = s;
    if (want_wr) exp_wr.push_back(w);
    if (want_cmp) exp_cmp.push_back(p);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ret_valid  = '0;
    squash_cmp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ret_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_wr.size() != 0 || exp_cmp.size() != 0) && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk({tag, " drained in time"}, 64'(k < 300), 64'd1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // dcache model: ack one cycle after each accepted request.
  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (dc_req_valid && dc_req_ready && !reset) begin
        @(posedge clock);
        #1;
        ack_auto = ack_en;
        @(posedge clock);
        #1;
        ack_auto = 1'b0;
      end
    end
  end

  // Monitor: compare every accepted write and every completion against the queues.
  initial begin
    wr_t w;
    logic [3:0] p;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dc_req_valid && dc_req_ready) begin
          if (exp_wr.size() == 0) unexpected("dc write", 64'(dc_req_addr));
          else begin
            w = exp_wr.pop_front();
            chk("dc addr", 64'(dc_req_addr), 64'(w.a));
            chk("dc data", 64'(dc_req_data), 64'(w.d));
            chk("dc size", 64'(dc_req_size), 64'(w.s));
          end
        end
        if (cmp_valid) begin
          cmp_seen++;
          if (exp_cmp.size() == 0) unexpected("cmp", 64'(cmp_pos));
          else begin
            p = exp_cmp.pop_front();
            chk("cmp pos", 64'(cmp_pos), 64'(p));
          end
        end
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; ret_valid = '0; ret_addr = '0; ret_data = '0; ret_size = '0; ret_pos = '0;
    squash_cmp = 1'b0; dc_req_ready = 1'b1; ack_man = 1'b0; ack_en = 1'b1;
    do_reset();

    // Reset state
    chk("rst buf_free", 64'(buf_free), 64'd8);
    chk("rst dc_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst dc_req_addr", 64'(dc_req_addr), 64'd0);
    chk("rst cmp_valid", 64'(cmp_valid), 64'd0);
    chk("rst cmp_pos", 64'(cmp_pos), 64'd0);
    chk("rst overflow", 64'(overflow_err), 64'd0);

    // Single store
    lane(0, 32'h100, 32'hDEADBEEF, 2'd2, 4'd3, 1, 1);
    step();
    chk("single req_valid t+1", 64'(dc_req_valid), 64'd1);
    chk("single req_addr t+1", 64'(dc_req_addr), 64'h100);
    chk("single buf_free t+1", 64'(buf_free), 64'd7);
    step();
    chk("single wait req_valid", 64'(dc_req_valid), 64'd0);
    chk("single wait cmp_valid", 64'(cmp_valid), 64'd0);
    step();
    chk("single cmp_valid", 64'(cmp_valid), 64'd1);
    chk("single buf_free after", 64'(buf_free), 64'd8);
    step();
    chk("single cmp one cycle", 64'(cmp_valid), 64'd0);
    drain("single");

    // Dual retire with a hole, then both lanes
    do_reset();
    lane(1, 32'h200, 32'h11112222, 2'd1, 4'd5, 1, 1);
    step();
    chk("hole buf_free", 64'(buf_free), 64'd7);
    chk("hole req_addr", 64'(dc_req_addr), 64'h200);
    drain("hole");
    lane(0, 32'h300, 32'hA0A0A0A0, 2'd2, 4'd6, 1, 1);
    lane(1, 32'h304, 32'hB1B1B1B1, 2'd0, 4'd7, 1, 1);
    step();
    chk("dual buf_free", 64'(buf_free), 64'd6);
    drain("dual");

    // Fill and overflow, then enqueue on a full buffer during a pop
    do_reset();
    dc_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      lane(0, 32'h1000 + 32'(8 * c), 32'h5000 + 32'(c), 2'd2, 4'(2 * c + 1), c < 4, c < 4);
      lane(1, 32'h1004 + 32'(8 * c), 32'h6000 + 32'(c), 2'd2, 4'(2 * c + 2), c < 4, c < 4);
      step();
      if (c == 3) begin
        chk("fill buf_free 0", 64'(buf_free), 64'd0);
        chk("fill no overflow yet", 64'(overflow_err), 64'd0);
      end
    end
    chk("fill overflow set", 64'(overflow_err), 64'd1);
    chk("fill buf_free still 0", 64'(buf_free), 64'd0);
    chk("fill head addr", 64'(dc_req_addr), 64'h1000);
    dc_req_ready = 1'b1;
    k = 0;
    while (!dc_ack && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("full pop ack seen", 64'(dc_ack), 64'd1);
    lane(0, 32'h2000, 32'h77777777, 2'd2, 4'd11, 1, 1);
    step();
    chk("full enq+pop buf_free", 64'(buf_free), 64'd0);
    drain("fill");
    chk("overflow sticky", 64'(overflow_err), 64'd1);
    chk("fill buf_free empty", 64'(buf_free), 64'd8);

    // Back-pressure
    do_reset();
    dc_req_ready = 1'b0;
    lane(0, 32'h400, 32'hCAFEF00D, 2'd0, 4'd9, 1, 1);
    step();
    for (int c = 0; c < 3; c++) begin
      chk("bp req_valid", 64'(dc_req_valid), 64'd1);
      chk("bp req_addr", 64'(dc_req_addr), 64'h400);
      chk("bp req_data", 64'(dc_req_data), 64'hCAFEF00D);
      chk("bp req_size", 64'(dc_req_size), 64'd0);
      chk("bp no cmp", 64'(cmp_valid), 64'd0);
      step();
    end
    dc_req_ready = 1'b1;
    drain("bp");

    // Squash: three buffered entries suppressed, the same-cycle retire completes
    do_reset();
    dc_req_ready = 1'b0;
    lane(0, 32'h500, 32'hC0, 2'd2, 4'd12, 1, 0);
    lane(1, 32'h504, 32'hC1, 2'd2, 4'd13, 1, 0);
    step();
    lane(0, 32'h508, 32'hC2, 2'd2, 4'd14, 1, 0);
    step();
    squash_cmp = 1'b1;
    lane(0, 32'h50C, 32'hC3, 2'd2, 4'd2, 1, 1);
    step();
    cmp_seen = 0;
    dc_req_ready = 1'b1;
    drain("squash");
    chk("squash cmp count", 64'(cmp_seen), 64'd1);

    // Reset while waiting for the ack
    do_reset();
    ack_en = 1'b0;
    lane(0, 32'h600, 32'h66666666, 2'd2, 4'd15, 1, 0);
    step();
    step();
    chk("rstwait in wait", 64'(dc_req_valid), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ack_man = 1'b1;
    @(posedge clock);
    #1;
    ack_man = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rstwait cmp_valid", 64'(cmp_valid), 64'd0);
      chk("rstwait buf_free", 64'(buf_free), 64'd8);
      chk("rstwait req_valid", 64'(dc_req_valid), 64'd0);
      step();
    end
    ack_en = 1'b1;

    chk("end wr queue empty", 64'(exp_wr.size()), 64'd0);
    chk("end cmp queue empty", 64'(exp_cmp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_retire_buffer.md
# store_retire_buffer

Buffers committed stores leaving the store queue and drains them one at a time into the data cache write port. It sits between the store queue's retire output and the dcache. Each completed write returns a one-cycle completion packet carrying the store-queue position, so the store queue can free that entry. Retired stores are architecturally committed, so a pipeline flush never drops buffered writes.

## Interface
- N_WAY, 2, retire lanes per cycle from the store queue
- DEPTH, 8, buffer entries; power of two, ≥ N_WAY
- XLEN, 32, address/data width
- POS_W, 4, store-queue position width; positions are 1-based, 0 = none
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ret_valid  in  N_WAY  per-lane retire valid from the store queue
- ret_addr  in  N_WAY×XLEN  store address
- ret_data  in  N_WAY×XLEN  store data, right-aligned
- ret_size  in  N_WAY×2  0=BYTE, 1=HALF, 2=WORD
- ret_pos  in  N_WAY×POS_W  store-queue position (1-based)
- squash_cmp  in  1  flush pulse; suppresses completions of entries already buffered
- buf_free  out  clog2(DEPTH)+1  free entries, from the registered count
- dc_req_valid  out  1  write request to the dcache
- dc_req_addr  out  XLEN  head address
- dc_req_data  out  XLEN  head data
- dc_req_size  out  2  head size
- dc_req_ready  in  1  dcache accepts the request this cycle
- dc_ack  in  1  dcache has committed the outstanding write
- cmp_valid  out  1  completion pulse to the store queue
- cmp_pos  out  POS_W  position of the completed store
- overflow_err  out  1  sticky; set if a valid lane was dropped

## Operation
- Circular FIFO with head/tail pointers modulo DEPTH and a count register (0..DEPTH).
- Each entry holds: addr, data, size, pos, suppress bit.
- Enqueue:
  - Valid lanes are taken in ascending lane order and compacted into consecutive tail slots. ret_valid need not be contiguous.
  - Lanes beyond the available space are dropped, and overflow_err is set. It clears only on reset.
  - Available space is buf_free plus the pop occurring that same cycle.
- squash_cmp: sets the suppress bit on every entry valid at the sampling edge, including the in-flight head. Entries enqueued in the same cycle are not suppressed. Writes to the dcache still complete.
- FSM, registered state:
  - IDLE: if the post-update count > 0, go to ISSUE.
  - ISSUE: dc_req_valid=1 with the head's fields. On dc_req_ready, go to WAIT. Fields stay stable until accepted. dc_ack is ignored in this state.
  - WAIT: dc_req_valid=0. On dc_ack:
    - pop the head;
    - register cmp_valid=!suppress and cmp_pos=pos;
    - go to ISSUE if count after the pop > 0, else IDLE.
  - At most one write is outstanding. dc_ack is ignored in IDLE.
- Count update: count_next = count + n_enq − pop.
- buf_free = DEPTH − count, from the registered value only.

## Timing
- Reset values:
  - count=0; head=tail=0; state=IDLE.
  - buf_free=DEPTH; overflow_err=0.
  - All dc_req_* = 0; cmp_valid=0; cmp_pos=0.
- Enqueue is written at the sampling edge and is visible the next cycle.
- If retire is presented in cycle t into an empty IDLE buffer, dc_req_valid=1 in cycle t+1.
- An accept in cycle a puts the FSM in WAIT in cycle a+1.
- A dc_ack sampled in cycle k gives:
  - cmp_valid high for exactly cycle k+1;
  - with more data pending, dc_req_valid for the next entry in cycle k+1.
  - Throughput: one store per ack plus one cycle.
- Simultaneous enqueue and pop when full: the slot freed by the pop is usable that cycle.
- Pointer wrap: from DEPTH−1 to 0, with no bubble.
- reset mid-WAIT: the outstanding write is abandoned and its completion is never reported. A later dc_ack is ignored because the FSM is in IDLE.

## Test plan
- Single store: reset; one cycle with lane0 valid, addr=0x100, data=0xDEADBEEF, size=WORD, pos=3. Expect:
  - dc_req_valid the next cycle with those fields;
  - ready=1 → WAIT;
  - ack → cmp_valid=1 with cmp_pos=3 for one cycle;
  - buf_free returns to 8.
- Dual retire with a hole: ret_valid=2'b10, pos=5. Expect the store in slot 0, buf_free=7, cmp_pos=5. Then present both lanes with pos=6,7. Expect writes and completions in order 6, 7.
- Fill and overflow: with ready held 0, retire 2 per cycle for 5 cycles. Expect:
  - buf_free reaches 0 after 4 cycles;
  - cycle 5 lanes dropped and overflow_err=1;
  - after draining, 8 completions in FIFO order.
- Back-pressure: hold dc_req_ready=0 for 3 cycles. Expect dc_req_* stable throughout and no completion before the ack.
- Squash: 3 entries buffered, then pulse squash_cmp, then retire pos=2 in the same cycle. Expect:
  - 4 dcache writes;
  - exactly one cmp_valid, with cmp_pos=2.
- Reset in WAIT: assert reset while waiting, then pulse dc_ack. Expect no cmp_valid, buf_free=8, dc_req_valid=0.
